// File: rtl/header.sv
// Shared loader types and constants for the program loader slice.
package header;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL,
    DONE
  } loader_state_t;

  localparam logic [31:0] STALL_INSTRUCTION = 32'h0C00_0000;
  localparam logic [7:0]  PROGRAM_START     = 8'h00;

endpackage

// File: rtl/program_word_packer.sv
// Packs a byte stream big-endian into 32-bit words.
module program_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] acc;

  assign word_valid = byte_valid && (lane == 2'd3);
  assign word       = {acc, byte_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane <= 2'd0;
      acc  <= 24'd0;
    end else begin
      if (byte_valid)
        acc <= {acc[15:0], byte_data};
      if (flush || word_valid)
        lane <= 2'd0;
      else if (byte_valid)
        lane <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a program image into instruction memory, fills the rest,
// and holds the CPU in reset until the image is complete.
module program_loader
  import header::*;
#(
  parameter logic [7:0]  PROGRAM_START = header::PROGRAM_START,
  parameter logic [31:0] FILL_WORD     = STALL_INSTRUCTION
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  prog_address,
  output logic        prog_write_enable,
  output logic [0:31] prog_wdata,
  output logic        cpu_run,
  output logic        done,
  output logic        error,
  output logic [8:0]  word_count
);

  loader_state_t state;
  logic [8:0]    next_addr;
  logic          xfer;
  logic          full;
  logic          restart;
  logic          flush;
  logic          word_valid;
  logic [31:0]   word;

  assign xfer    = in_valid & in_ready;
  // Bit 8 set means every address up to 8'hFF is used.
  assign full    = next_addr[8];
  assign restart = start & ((state == IDLE) | (state == DONE));
  assign flush   = restart | (xfer & in_last);

  program_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .byte_valid (xfer & ~full),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      next_addr         <= {1'b0, PROGRAM_START};
      in_ready          <= 1'b0;
      prog_address      <= PROGRAM_START;
      prog_write_enable <= 1'b0;
      prog_wdata        <= 32'd0;
      cpu_run           <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      word_count        <= 9'd0;
    end else begin
      prog_write_enable <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            next_addr  <= {1'b0, PROGRAM_START};
            in_ready   <= 1'b1;
            cpu_run    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 9'd0;
          end
        end
        LOAD: begin
          if (word_valid) begin
            prog_write_enable <= 1'b1;
            prog_address      <= next_addr[7:0];
            prog_wdata        <= word;
            next_addr         <= next_addr + 9'd1;
            word_count        <= word_count + 9'd1;
          end
          if (xfer && full)
            error <= 1'b1;
          if (xfer && in_last) begin
            in_ready <= 1'b0;
            if (!word_valid && !full)
              error <= 1'b1;
            if (full) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (full) begin
            state   <= DONE;
            done    <= 1'b1;
            cpu_run <= 1'b1;
          end else begin
            prog_write_enable <= 1'b1;
            prog_address      <= next_addr[7:0];
            prog_wdata        <= FILL_WORD;
            next_addr         <= next_addr + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised self-checking bench for program_loader.
module tb_program_loader;
  import header::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  prog_address;
  logic        prog_write_enable;
  logic [0:31] prog_wdata;
  logic        cpu_run;
  logic        done;
  logic        error;
  logic [8:0]  word_count;

  program_loader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_last           (in_last),
    .in_ready          (in_ready),
    .prog_address      (prog_address),
    .prog_write_enable (prog_write_enable),
    .prog_wdata        (prog_wdata),
    .cpu_run           (cpu_run),
    .done              (done),
    .error             (error),
    .word_count        (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc;

  logic [7:0]  img [0:1199];
  logic [39:0] wq[$];
  int          wc[$];
  logic [39:0] eq[$];
  int          e_loaded;
  logic        e_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && prog_write_enable) begin
      wq.push_back({prog_address, 32'(prog_wdata)});
      wc.push_back(cyc);
      checks++;
      if (done || cpu_run) begin
        errors++;
        $display("FAIL we_while_done: done=%b cpu_run=%b want 0", done, cpu_run);
      end
    end
  end

  task automatic build_expected(input int n);
    int nfull;
    eq.delete();
    nfull = n / 4;
    e_loaded = (nfull > 256) ? 256 : nfull;
    for (int i = 0; i < e_loaded; i++)
      eq.push_back({8'(i), img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]});
    if (n <= 1024)
      for (int a = e_loaded; a < 256; a++)
        eq.push_back({8'(a), STALL_INSTRUCTION});
    e_err = (n % 4 != 0) || (n > 1024);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    wq.delete();
    wc.delete();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drive_bytes(input int n, input int gap, input bit with_last);
    for (int i = 0; i < n; i++) begin
      if (gap == 1 && i > 0) @(posedge clk);
      if (gap == 2) repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = img[i];
      in_last  = with_last && (i == n - 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    @(negedge clk);
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    done_cyc = cyc;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s done_timeout: done=%b want 1", name, done);
    end
  endtask

  task automatic test_image(input string name, input int n,
                            input int gap, input bit poke_fill);
    int step;
    build_expected(n);
    pulse_start();
    checks++;
    if ({in_ready, done, cpu_run, error, word_count} !== {3'b100, 1'b0, 9'd0}) begin
      errors++;
      $display("FAIL %s start_state: rdy/done/run/err/wc=%b/%b/%b/%b/%0d want 1/0/0/0/0",
               name, in_ready, done, cpu_run, error, word_count);
    end
    drive_bytes(n, gap, 1'b1);
    if (poke_fill) begin
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done(name);
    checks++;
    if (wq.size() != eq.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", name, wq.size(), eq.size());
    end
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      checks++;
      if (wq[i] !== eq[i]) begin
        errors++;
        $display("FAIL %s write[%0d]: got %h want %h", name, i, wq[i], eq[i]);
      end
    end
    step = (gap == 1) ? 8 : 4;
    for (int i = 1; i < wc.size(); i++) begin
      if (i < e_loaded && gap != 2) begin
        checks++;
        if (wc[i] - wc[i-1] != step) begin
          errors++;
          $display("FAIL %s load_spacing[%0d]: got %0d want %0d", name, i, wc[i]-wc[i-1], step);
        end
      end else if (i > e_loaded || (i == e_loaded && n % 4 == 0)) begin
        checks++;
        if (wc[i] - wc[i-1] != 1) begin
          errors++;
          $display("FAIL %s fill_spacing[%0d]: got %0d want 1", name, i, wc[i]-wc[i-1]);
        end
      end
    end
    if (n <= 1024 && wc.size() > 0) begin
      checks++;
      if (done_cyc != wc[wc.size()-1] + 1) begin
        errors++;
        $display("FAIL %s done_timing: got cycle %0d want %0d", name, done_cyc, wc[wc.size()-1] + 1);
      end
    end
    checks++;
    if ({cpu_run, in_ready, error, word_count} !== {1'b1, 1'b0, e_err, 9'(e_loaded)}) begin
      errors++;
      $display("FAIL %s status: run/rdy/err/wc=%b/%b/%b/%0d want 1/0/%b/%0d",
               name, cpu_run, in_ready, error, word_count, e_err, e_loaded);
    end
  endtask

  task automatic load_four_word();
    logic [7:0] b [0:15];
    b = '{8'h10, 8'h00, 8'h00, 8'h0C, 8'h10, 8'h10, 8'h00, 8'h0C,
          8'h20, 8'h20, 8'h10, 8'h00, 8'h30, 8'h0F, 8'h20, 8'h00};
    for (int i = 0; i < 16; i++) img[i] = b[i];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, prog_write_enable, prog_address, 32'(prog_wdata),
         cpu_run, done, error, word_count} !== 54'd0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%h data=%h run=%b done=%b err=%b wc=%0d want all 0",
               in_ready, prog_write_enable, prog_address, prog_wdata, cpu_run, done, error, word_count);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, cpu_run, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_state: rdy=%b run=%b done=%b want 0", in_ready, cpu_run, done);
    end
  endtask

  task automatic test_four_word();
    load_four_word();
    test_image("four_word", 16, 0, 1'b0);
    checks++;
    if (wq.size() < 4 || wq[3] !== {8'h03, 32'h300F2000}) begin
      errors++;
      $display("FAIL four_word_direct: got %h want %h", (wq.size() > 3) ? wq[3] : 40'h0,
               {8'h03, 32'h300F2000});
    end
  endtask

  task automatic test_gaps();
    load_four_word();
    test_image("valid_gaps", 16, 1, 1'b0);
  endtask

  task automatic test_truncated();
    for (int i = 0; i < 6; i++) img[i] = 8'($urandom);
    test_image("truncated", 6, 0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 1029; i++) img[i] = 8'($urandom);
    test_image("overflow", 1029, 0, 1'b0);
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
    pulse_start();
    drive_bytes(8, 0, 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, prog_write_enable, prog_address, 32'(prog_wdata),
         cpu_run, done, error, word_count} !== 54'd0) begin
      errors++;
      $display("FAIL midload_reset: rdy=%b we=%b addr=%h data=%h run=%b done=%b err=%b wc=%0d want all 0",
               in_ready, prog_write_enable, prog_address, prog_wdata, cpu_run, done, error, word_count);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
    test_image("reset_restart", 4, 0, 1'b0);
  endtask

  task automatic test_restart_and_fill_start();
    load_four_word();
    test_image("restart_from_done", 16, 0, 1'b0);
    for (int i = 0; i < 12; i++) img[i] = 8'($urandom);
    test_image("start_in_fill", 12, 0, 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 48);
      for (int i = 0; i < n; i++) img[i] = 8'($urandom);
      test_image("random", n, 2, 1'b0);
    end
  endtask

  initial begin
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    test_reset();
    test_four_word();
    test_gaps();
    test_truncated();
    test_overflow();
    test_reset_midload();
    test_restart_and_fill_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
